// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared state encoding and default sizing for the FIFO write-arbiter slice.
package fifo_ctrl_pkg;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_BURST_MAX = 4;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/consumer side of the write arbiter: requests, grant, FIFO write path and occupancy flags.
interface fifo_wr_arbiter_if
  import fifo_ctrl_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               wr_ack;
  logic               fifo_w_en;
  logic [DW-1:0]      fifo_data_in;
  logic               fifo_r_en;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;
  logic               half_full;
  logic               almost_full;

  modport master (
    output req, req_data, fifo_r_en,
    input  gnt, wr_ack, fifo_w_en, fifo_data_in, count, full, empty, half_full, almost_full
  );

  modport slave (
    input  req, req_data, fifo_r_en,
    output gnt, wr_ack, fifo_w_en, fifo_data_in, count, full, empty, half_full, almost_full
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request scanning from last+1, wrapping at NREQ-1.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx
);
  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      logic [IW:0]   sum;
      logic [IW-1:0] j;
      sum = {1'b0, last} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      j = sum[IW-1:0];
      if (req[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = j;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-limited round-robin arbiter feeding one shared FIFO write port; tracks occupancy from writes and reads.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DW        = DEF_DW,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic              clk,
  input  logic              reset,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(BURST_MAX) + 1;

  logic [0:0]             state;
  logic [NREQ-1:0]        gnt;
  logic [IW-1:0]          owner;
  logic [IW-1:0]          last_winner;
  logic [IW-1:0]          pick_idx;
  logic [NREQ-1:0]        pick_oh;
  logic [BW-1:0]          beat_cnt;
  logic [CW-1:0]          count;
  logic [NREQ-1:0][DW-1:0] lane_data;
  logic                   full;
  logic                   empty;
  logic                   wr;
  logic                   rd;
  logic                   burst_end;

  assign lane_data = bus.req_data;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (bus.req),
    .last   (last_winner),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  assign full  = (count == CW'(DEPTH-1));
  assign empty = (count == '0);

  // Writes are suppressed in a reset cycle so an aborted burst leaves nothing behind.
  assign wr        = (state == BURST) & bus.req[owner] & ~full & ~reset;
  assign rd        = bus.fifo_r_en & ~empty;
  assign burst_end = (state == BURST) &
                     (~bus.req[owner] | (wr & (beat_cnt == BW'(BURST_MAX-1))));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= '0;
      owner       <= '0;
      last_winner <= IW'(NREQ-1);
      beat_cnt    <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.req) begin
          state    <= BURST;
          gnt      <= pick_oh;
          owner    <= pick_idx;
          beat_cnt <= '0;
        end
        BURST: if (burst_end) begin
          state       <= IDLE;
          gnt         <= '0;
          last_winner <= owner;
          beat_cnt    <= '0;
        end else if (wr) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase

      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.gnt          = gnt;
  assign bus.wr_ack       = wr;
  assign bus.fifo_w_en    = wr;
  assign bus.fifo_data_in = (state == BURST) ? lane_data[owner] : '0;
  assign bus.count        = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.half_full    = (count >= CW'(DEPTH/2));
  assign bus.almost_full  = (count >= CW'(DEPTH-2));
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scenarios plus randomized traffic against a cycle-level behavioural model of the arbiter.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4, DW = 8, DEPTH = 8, BURST_MAX = 4;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) bus();

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .BURST_MAX(BURST_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who holds the grant, beats taken, who won last, FIFO occupancy.
  bit m_valid = 0;
  bit m_burst = 0;
  int m_owner = 0, m_last = NREQ-1, m_beats = 0, m_cnt = 0;

  always @(negedge clk) begin : model
    logic [NREQ-1:0] eg;
    logic [DW-1:0]   ed;
    bit              ewr, rd, own_req;
    own_req = m_burst && (((bus.req >> m_owner) & 1) != 0);
    ewr = own_req && (m_cnt != DEPTH-1) && !reset;
    eg  = m_burst ? NREQ'(1 << m_owner) : '0;
    ed  = m_burst ? DW'(bus.req_data >> (m_owner*DW)) : '0;
    if (m_valid) begin
      check("gnt", 32'(bus.gnt), 32'(eg));
      check("wr_ack", 32'(bus.wr_ack), 32'(ewr));
      check("fifo_w_en", 32'(bus.fifo_w_en), 32'(ewr));
      check("fifo_data_in", 32'(bus.fifo_data_in), 32'(ed));
      check("count", 32'(bus.count), 32'(m_cnt));
      check("empty", 32'(bus.empty), 32'(m_cnt == 0));
      check("full", 32'(bus.full), 32'(m_cnt == DEPTH-1));
      check("half_full", 32'(bus.half_full), 32'(m_cnt >= DEPTH/2));
      check("almost_full", 32'(bus.almost_full), 32'(m_cnt >= DEPTH-2));
    end
    if (reset) begin
      m_valid = 1; m_burst = 0; m_owner = 0; m_last = NREQ-1; m_beats = 0; m_cnt = 0;
    end else begin
      rd = bus.fifo_r_en && (m_cnt > 0);
      m_cnt = m_cnt + int'(ewr) - int'(rd);
      if (!m_burst) begin
        for (int k = NREQ; k >= 1; k--)
          if (((bus.req >> ((m_last + k) % NREQ)) & 1) != 0) begin
            m_owner = (m_last + k) % NREQ;
            m_burst = 1;
            m_beats = 0;
          end
      end else if (!own_req) begin
        m_burst = 0; m_last = m_owner;
      end else if (ewr) begin
        m_beats++;
        if (m_beats == BURST_MAX) begin m_burst = 0; m_last = m_owner; end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; bus.req = '0; bus.fifo_r_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, nb, c;
    logic [7:0] pat, seen, emp_t, hf_t, af_t, fu_t;
    logic [3:0] g, prev, g1;
    logic [3:0] eg [5];
    int blen [8];
    logic [7:0] wlog [6];

    reset = 1'b1; bus.req = '0; bus.req_data = '0; bus.fifo_r_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_wr_ack", 32'(bus.wr_ack), 32'h0);
    check("rst_data", 32'(bus.fifo_data_in), 32'h0);
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_flags", 32'({bus.empty, bus.full, bus.half_full, bus.almost_full}), 32'h8);

    // Single requester, six beats: 4-beat burst, idle cycle, regrant for the rest.
    sent = 0; pat = '0; g1 = '0;
    for (int it = 0; it < 9; it++) begin
      cyc();
      bus.req = (sent < 6) ? 4'b0001 : 4'b0000;
      bus.req_data[7:0] = 8'h11 + sent[7:0];
      @(negedge clk);
      if (it < 8) pat[it] = bus.wr_ack;
      if (it == 1) g1 = bus.gnt;
      if (bus.wr_ack && sent < 6) begin wlog[sent] = bus.fifo_data_in; sent++; end
    end
    check("single_gnt", 32'(g1), 32'h1);
    check("single_pattern", 32'(pat), 32'b1101_1110);
    check("single_count", 32'(bus.count), 32'd6);
    for (int i = 0; i < 6; i++) check("single_data", 32'(wlog[i]), 32'h11 + 32'(i));

    // Fairness with all requesting and the consumer draining.
    do_reset();
    prev = '0; nb = 0;
    for (int i = 0; i < 8; i++) blen[i] = 0;
    bus.fifo_r_en = 1'b1;
    for (int it = 0; it < 26; it++) begin
      cyc();
      bus.req = 4'b1111; bus.req_data = 32'($urandom);
      @(negedge clk);
      g = bus.gnt;
      if (g != 0 && prev == 0) begin if (nb < 8) blen[nb] = 0; nb++; end
      if (g != 0 && prev == 0 && nb <= 5) eg[nb-1] = g;
      if (g != 0 && bus.wr_ack && nb > 0 && nb <= 8) blen[nb-1]++;
      prev = g;
    end
    check("fair_ngrants", 32'(nb >= 5), 32'd1);
    if (nb >= 5) begin
      check("fair_g0", 32'(eg[0]), 32'h1);
      check("fair_g1", 32'(eg[1]), 32'h2);
      check("fair_g2", 32'(eg[2]), 32'h4);
      check("fair_g3", 32'(eg[3]), 32'h8);
      check("fair_g4", 32'(eg[4]), 32'h1);
      for (int i = 0; i < 5; i++) check("fair_len", 32'(blen[i]), 32'd4);
    end

    // Full stall, one read, one refill write.
    do_reset();
    for (int it = 0; it < 30; it++) begin
      cyc(); bus.req = 4'b0001;
      @(negedge clk);
      if (bus.count == 7) break;
    end
    check("stall_fill", 32'(bus.count), 32'd7);
    for (int it = 0; it < 3; it++) begin cyc(); bus.req = 4'b0010; bus.req_data[15:8] = 8'hA5; end
    @(negedge clk);
    check("stall_gnt", 32'(bus.gnt), 32'h2);
    check("stall_wr", 32'(bus.wr_ack), 32'h0);
    cyc(); bus.fifo_r_en = 1'b1;
    @(negedge clk);
    check("stall_rd_cycle_wr", 32'(bus.wr_ack), 32'h0);
    cyc(); bus.fifo_r_en = 1'b0;
    @(negedge clk);
    check("stall_after_rd_count", 32'(bus.count), 32'd6);
    check("stall_after_rd_wr", 32'(bus.wr_ack), 32'h1);
    cyc();
    @(negedge clk);
    check("stall_refill_count", 32'(bus.count), 32'd7);
    check("stall_refill_wr", 32'(bus.wr_ack), 32'h0);

    // Simultaneous write and read, then read at empty.
    do_reset();
    for (int it = 0; it < 11; it++) begin
      cyc();
      bus.req = (it <= 4) ? 4'b0001 : 4'b0000;
      bus.fifo_r_en = (it >= 4);
      @(negedge clk);
      if (it == 4) begin
        check("simul_pre_count", 32'(bus.count), 32'd3);
        check("simul_wr", 32'(bus.wr_ack), 32'h1);
      end
      if (it == 5) check("simul_count", 32'(bus.count), 32'd3);
      if (it == 10) begin
        check("empty_read_count", 32'(bus.count), 32'd0);
        check("empty_read_flag", 32'(bus.empty), 32'h1);
      end
    end

    // Flag sweep across every occupancy.
    do_reset();
    seen = '0; emp_t = 8'h01; hf_t = 8'hF0; af_t = 8'hC0; fu_t = 8'h80;
    for (int it = 0; it < 20; it++) begin
      cyc(); bus.req = 4'b0001;
      @(negedge clk);
      c = int'(bus.count);
      if (c >= 0 && c < 8) begin
        seen[c] = 1'b1;
        check("sweep_empty", 32'(bus.empty), 32'(emp_t[c]));
        check("sweep_half", 32'(bus.half_full), 32'(hf_t[c]));
        check("sweep_almost", 32'(bus.almost_full), 32'(af_t[c]));
        check("sweep_full", 32'(bus.full), 32'(fu_t[c]));
      end
      if (c == 7) break;
    end
    check("sweep_cover", 32'(seen), 32'hFF);

    // Reset in the middle of a burst to requester 2.
    do_reset();
    cyc(); bus.req = 4'b0100;
    cyc();
    cyc(); reset = 1'b1;
    @(negedge clk);
    check("midrst_gnt", 32'(bus.gnt), 32'h4);
    check("midrst_wr", 32'(bus.wr_ack), 32'h0);
    cyc(); reset = 1'b0; bus.req = 4'b1111;
    @(negedge clk);
    check("midrst_gnt_clear", 32'(bus.gnt), 32'h0);
    check("midrst_count", 32'(bus.count), 32'h0);
    cyc();
    @(negedge clk);
    check("midrst_regrant", 32'(bus.gnt), 32'h1);

    // Randomized traffic; the model checks every cycle.
    do_reset();
    for (int it = 0; it < 1500; it++) begin
      cyc();
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 7) == 0) bus.req[i] = ~bus.req[i];
      bus.req_data = 32'($urandom);
      bus.fifo_r_en = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 199) == 0);
    end
    cyc(); reset = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
